// File: rtl/io_responder.sv
// Memory-mapped I/O responder for the 0xFFFFF000 page: digit/LED/timer registers, synchronized
// switch and button inputs, and a scanned eight-digit seven-segment display. Timer under IO_TIMER_EN.
module io_responder #(
  parameter int unsigned SCAN_DIV  = 20000,
  parameter int unsigned TIMER_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs_from_bridge,
  input  logic [11:0] addr_from_bridge,
  input  logic        we_from_bridge,
  input  logic [31:0] wdata_from_bridge,
  output logic [31:0] rdata_to_bridge,
  input  logic [23:0] sw,
  input  logic [4:0]  btn,
  output logic [23:0] led,
  output logic [7:0]  dig_en,
  output logic [7:0]  dig_seg
);

  localparam logic [11:0] AddrDig   = 12'h000;
  localparam logic [11:0] AddrTimer = 12'h020;
  localparam logic [11:0] AddrLed   = 12'h060;
  localparam logic [11:0] AddrSw    = 12'h070;
  localparam logic [11:0] AddrBtn   = 12'h078;

  localparam int unsigned PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PMax = PW'(SCAN_DIV - 1);

  typedef enum logic [2:0] {
    StDig0, StDig1, StDig2, StDig3, StDig4, StDig5, StDig6, StDig7
  } digit_e;

  digit_e        d_q, d_nxt;
  logic [PW-1:0] p_q, p_nxt;
  logic [7:0]    seg_q, seg_nxt;
  logic [31:0]   dig_q;
  logic [23:0]   led_q;
  logic [23:0]   sw_s1, sw_s2;
  logic [4:0]    btn_s1, btn_s2;
  logic [31:0]   timer_rd;
  logic          wr;
  logic [3:0]    nibble;

  assign wr = cs_from_bridge && we_from_bridge;

  // Active-low {G,F,E,D,C,B,A} pattern for one hex digit.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig_q  <= '0;
      led_q  <= '0;
      sw_s1  <= '0;
      sw_s2  <= '0;
      btn_s1 <= '0;
      btn_s2 <= '0;
    end else begin
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
      btn_s1 <= btn;
      btn_s2 <= btn_s1;
      if (wr && addr_from_bridge == AddrDig) dig_q <= wdata_from_bridge;
      if (wr && addr_from_bridge == AddrLed) led_q <= wdata_from_bridge[23:0];
    end
  end

  // Scan FSM: state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q   <= StDig0;
      p_q   <= '0;
      seg_q <= 8'hC0;
    end else begin
      d_q   <= d_nxt;
      p_q   <= p_nxt;
      seg_q <= seg_nxt;
    end
  end

  // Segments are decoded for the digit that becomes active on this edge, keeping them in step.
  always_comb begin
    d_nxt = d_q;
    p_nxt = p_q + 1'b1;
    if (p_q == PMax) begin
      p_nxt = '0;
      d_nxt = digit_e'(d_q + 3'd1);
    end
    nibble  = dig_q[{d_nxt, 2'b00} +: 4];
    seg_nxt = {1'b1, hex7(nibble)};
  end

`ifdef IO_TIMER_EN
  localparam int unsigned TW = $clog2(TIMER_DIV);
  localparam logic [TW-1:0] TMax = TW'(TIMER_DIV - 1);

  logic [TW-1:0] t_q;
  logic [31:0]   timer_q;

  // A write on the tick cycle wins; that tick is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_q     <= '0;
      timer_q <= '0;
    end else if (wr && addr_from_bridge == AddrTimer) begin
      t_q     <= '0;
      timer_q <= wdata_from_bridge;
    end else if (t_q == TMax) begin
      t_q     <= '0;
      timer_q <= timer_q + 32'd1;
    end else begin
      t_q <= t_q + 1'b1;
    end
  end

  assign timer_rd = timer_q;
`else
  localparam int unsigned UnusedTimerDiv = TIMER_DIV;
  assign timer_rd = '0;
`endif

  always_comb begin
    rdata_to_bridge = '0;
    if (cs_from_bridge) begin
      case (addr_from_bridge)
        AddrDig:   rdata_to_bridge = dig_q;
        AddrTimer: rdata_to_bridge = timer_rd;
        AddrLed:   rdata_to_bridge = {8'h00, led_q};
        AddrSw:    rdata_to_bridge = {8'h00, sw_s2};
        AddrBtn:   rdata_to_bridge = {27'h0, btn_s2};
        default:   rdata_to_bridge = '0;
      endcase
    end
  end

  assign led     = led_q;
  assign dig_en  = ~(8'b1 << d_q);
  assign dig_seg = seg_q;

endmodule

// File: tb/tb_io_responder.sv
// Scoreboard bench for io_responder (SCAN_DIV=4, TIMER_DIV=3); timer checks follow IO_TIMER_EN.
module tb_io_responder;

  localparam int unsigned SCAN_DIV  = 4;
  localparam int unsigned TIMER_DIV = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cs = 1'b0;
  logic [11:0] addr = '0;
  logic        we = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic [23:0] sw = '0;
  logic [4:0]  btn = '0;
  logic [23:0] led;
  logic [7:0]  dig_en;
  logic [7:0]  dig_seg;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_dig = '0;
  logic [23:0] model_led = '0;
  logic [7:0]  seg_tab[16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  io_responder #(.SCAN_DIV(SCAN_DIV), .TIMER_DIV(TIMER_DIV)) dut (
    .clk               (clk),
    .rst               (rst),
    .cs_from_bridge    (cs),
    .addr_from_bridge  (addr),
    .we_from_bridge    (we),
    .wdata_from_bridge (wdata),
    .rdata_to_bridge   (rdata),
    .sw                (sw),
    .btn               (btn),
    .led               (led),
    .dig_en            (dig_en),
    .dig_seg           (dig_seg)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic bus_write(input logic [11:0] a, input logic [31:0] d, input logic c = 1'b1);
    @(negedge clk);
    cs = c; we = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    #1;
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [11:0] a, output logic [31:0] d);
    cs = 1'b1; we = 1'b0; addr = a;
    #1;
    d = rdata;
    cs = 1'b0;
  endtask

  // Read an address and compare against the oldest queued expectation.
  task automatic read_expect(input string name, input logic [11:0] a);
    logic [31:0] got, exp;
    bus_read(a, got);
    exp = exp_q.pop_front();
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    logic [31:0] exp_timer;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    model_dig = '0;
    model_led = '0;
    n_tests++;
    if (led !== 24'h0) begin n_fail++; $display("FAIL reset_led: got %h want 0", led); end
    n_tests++;
    if (dig_en !== 8'hFE) begin n_fail++; $display("FAIL reset_dig_en: got %h want fe", dig_en); end
    n_tests++;
    if (dig_seg !== 8'hC0) begin n_fail++; $display("FAIL reset_dig_seg: got %h want c0", dig_seg); end
    exp_q.push_back(32'h0);
    read_expect("reset_dig_read", 12'h000);
    exp_q.push_back(32'h0);
    read_expect("reset_sw_read", 12'h070);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(32'h0);
    read_expect("reset_timer_pre_tick", 12'h020);
    @(posedge clk);
    #1;
`ifdef IO_TIMER_EN
    exp_timer = 32'd1;
`else
    exp_timer = 32'd0;
`endif
    exp_q.push_back(exp_timer);
    read_expect("reset_timer_first_tick", 12'h020);
    n_tests++;
    if (dig_en !== 8'hFE) begin n_fail++; $display("FAIL reset_no_early_advance: got %h want fe", dig_en); end
    @(posedge clk);
    #1;
    n_tests++;
    if (dig_en !== 8'hFD) begin n_fail++; $display("FAIL reset_first_advance: got %h want fd", dig_en); end
  endtask

  task automatic test_led();
    bus_write(12'h060, 32'hFFABCDEF);
    model_led = 24'hABCDEF;
    n_tests++;
    if (led !== model_led) begin n_fail++; $display("FAIL led_port: got %h want %h", led, model_led); end
    exp_q.push_back({8'h00, model_led});
    read_expect("led_read", 12'h060);
    bus_write(12'h060, 32'h00123456, 1'b0);
    n_tests++;
    if (led !== model_led) begin n_fail++; $display("FAIL led_cs_low_write: got %h want %h", led, model_led); end
    exp_q.push_back({8'h00, model_led});
    read_expect("led_read_after_cs_low", 12'h060);
    cs = 1'b0; addr = 12'h060;
    #1;
    n_tests++;
    if (rdata !== 32'h0) begin n_fail++; $display("FAIL read_gated_by_cs: got %h want 0", rdata); end
  endtask

  task automatic test_sw_btn();
    @(negedge clk);
    sw = 24'h5A5A5A; btn = 5'b10011;
    @(posedge clk);
    #1;
    exp_q.push_back(32'h0);
    read_expect("sw_one_edge_old", 12'h070);
    exp_q.push_back(32'h0);
    read_expect("btn_one_edge_old", 12'h078);
    @(posedge clk);
    #1;
    exp_q.push_back(32'h005A5A5A);
    read_expect("sw_synced", 12'h070);
    exp_q.push_back(32'h00000013);
    read_expect("btn_synced", 12'h078);
    bus_write(12'h070, 32'hFFFFFFFF);
    exp_q.push_back(32'h005A5A5A);
    read_expect("sw_write_ignored", 12'h070);
  endtask

  task automatic test_scan();
    int cur, cnt, first;
    logic [7:0] prev_en;
    bus_write(12'h000, 32'h8765F210);
    model_dig = 32'h8765F210;
    exp_q.push_back(model_dig);
    read_expect("dig_read", 12'h000);
    @(posedge clk);
    #1;
    cur = -1;
    for (int i = 0; i < 8; i++) if (dig_en == ~(8'b1 << i)) cur = i;
    n_tests++;
    if (cur < 0) begin
      n_fail++;
      $display("FAIL scan_one_cold: got %h want single low bit", dig_en);
      return;
    end
    n_tests++;
    if (dig_seg !== seg_tab[model_dig[4*cur +: 4]]) begin
      n_fail++;
      $display("FAIL scan_seg_d%0d: got %h want %h", cur, dig_seg, seg_tab[model_dig[4*cur +: 4]]);
    end
    first = 1;
    for (int k = 0; k < 9; k++) begin
      prev_en = dig_en;
      cnt = 0;
      while (dig_en === prev_en && cnt < 2 * SCAN_DIV) begin
        @(posedge clk);
        #1;
        cnt++;
      end
      cur = (cur + 1) % 8;
      exp_q.push_back({24'h0, ~(8'b1 << cur)});
      exp_q.push_back({24'h0, seg_tab[model_dig[4*cur +: 4]]});
      n_tests++;
      if (!first && cnt != SCAN_DIV) begin
        n_fail++;
        $display("FAIL scan_dwell: got %0d cycles want %0d", cnt, SCAN_DIV);
      end
      first = 0;
      n_tests++;
      if ({24'h0, dig_en} !== exp_q[0]) begin
        n_fail++;
        $display("FAIL scan_en_d%0d: got %h want %h", cur, dig_en, exp_q[0][7:0]);
      end
      void'(exp_q.pop_front());
      n_tests++;
      if ({24'h0, dig_seg} !== exp_q[0]) begin
        n_fail++;
        $display("FAIL scan_seg_d%0d: got %h want %h", cur, dig_seg, exp_q[0][7:0]);
      end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_timer();
`ifdef IO_TIMER_EN
    bus_write(12'h020, 32'hFFFFFFFF);
    exp_q.push_back(32'hFFFFFFFF);
    read_expect("timer_load", 12'h020);
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      #1;
      exp_q.push_back(i == 3 ? 32'h0 : 32'hFFFFFFFF);
      read_expect("timer_wrap", 12'h020);
    end
    repeat (2) @(posedge clk);
    bus_write(12'h020, 32'd5);
    exp_q.push_back(32'd5);
    read_expect("timer_write_beats_tick", 12'h020);
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      #1;
      exp_q.push_back(i == 3 ? 32'd6 : 32'd5);
      read_expect("timer_after_write", 12'h020);
    end
`else
    bus_write(12'h020, 32'h12345678);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(32'h0);
      read_expect("timer_absent", 12'h020);
      @(posedge clk);
      #1;
    end
`endif
  endtask

  task automatic test_unmapped();
`ifdef IO_TIMER_EN
    bus_write(12'h020, 32'd100);
`endif
    bus_write(12'h044, 32'h12345678);
    exp_q.push_back(32'h0);
    read_expect("unmapped_read", 12'h044);
    exp_q.push_back(model_dig);
    read_expect("unmapped_dig_kept", 12'h000);
    exp_q.push_back({8'h00, model_led});
    read_expect("unmapped_led_kept", 12'h060);
`ifdef IO_TIMER_EN
    exp_q.push_back(32'd100);
`else
    exp_q.push_back(32'd0);
`endif
    read_expect("unmapped_timer_kept", 12'h020);
  endtask

  initial begin
    test_reset();
    test_led();
    test_sw_btn();
    test_scan();
    test_timer();
    test_unmapped();
    test_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
